// File: rtl/frame_pkg.sv
// Shared definitions for the frame parser: header default, error codes,
// FSM state encoding and the checksum accumulate helper.
package frame_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // err_code values reported alongside frame_err
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  // Running checksum: 8-bit wrap-around sum
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Starvation counter for the frame parser.
// Ports:
//   clk, resetn - clock and asynchronous active-low reset
//   clear       - zero the counter (pop or state change); wins over run
//   run         - inside a frame with an empty FIFO: count one cycle
//   expired     - run is high and the counter sits at TIMEOUT_CYCLES-1
module frame_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  assign expired = run && (timer == LIMIT);

  // Counter register: cleared on activity, advances only while starved
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (run && !expired) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= timer;
    end
  end

endmodule

// File: rtl/frame_parser.sv
// Frame parser: hunts for HDR in the receive FIFO window, validates LEN,
// streams the payload downstream with valid/ready and checks the trailing
// checksum (LEN + payload, mod 256).
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   enable               - low freezes all state, no pops, no pulses
//   fifo_data/fifo_level - FIFO window ([7:0] oldest) and fill level
//   fifo_r_en/r_count    - combinational pop request (1 or 2 bytes)
//   m_data/m_valid/m_last/m_ready - payload stream
//   frame_ok/frame_err/err_code   - registered end-of-frame status pulses
module frame_parser
  import frame_pkg::*;
#(
  parameter int         WIN            = 2,
  parameter logic [7:0] HDR            = HDR_DEFAULT,
  parameter int         MAX_PAYLOAD    = 32,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         LEVEL_W        = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic [WIN*8-1:0]   fifo_data,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_r_en,
  output logic [5:0]         fifo_r_count,
  output logic [7:0]         m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               frame_ok,
  output logic               frame_err,
  output logic [1:0]         err_code
);

  localparam int         REM_W   = $clog2(MAX_PAYLOAD + 1);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t           state, state_next;
  logic [7:0]       sum, sum_next;
  logic [REM_W-1:0] remaining, remaining_next;
  logic             ok_next, err_next;
  logic [1:0]       code_next;
  logic [7:0]       byte0, byte1;
  logic             has1, has2;
  logic             timer_run, timer_clear, expired;

  assign byte0 = fifo_data[7:0];
  assign byte1 = fifo_data[15:8];
  assign has1  = (fifo_level >= LEVEL_W'(1));
  assign has2  = (fifo_level >= LEVEL_W'(2));

  assign m_data = byte0;
  assign m_last = m_valid && (remaining == REM_W'(1));

  // Back-pressure keeps has1 high, so it never feeds the starvation timer
  assign timer_run   = enable && resetn && !has1 &&
                       ((state == ST_PAYLOAD) || (state == ST_CHECK));
  assign timer_clear = fifo_r_en || (state_next != state);

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (timer_clear),
    .run    (timer_run),
    .expired(expired)
  );

  // Next-state, pop request and stream handshake
  always_comb begin
    state_next     = state;
    sum_next       = sum;
    remaining_next = remaining;
    fifo_r_en      = 1'b0;
    fifo_r_count   = 6'd0;
    m_valid        = 1'b0;
    ok_next        = 1'b0;
    err_next       = 1'b0;
    code_next      = ERR_NONE;
    // Also gated by resetn so no byte is popped while held in reset
    if (enable && resetn) begin
      case (state)
        ST_IDLE: begin
          if (!has1) begin
            state_next = ST_IDLE;
          end else if (byte0 != HDR) begin
            fifo_r_en    = 1'b1;
            fifo_r_count = 6'd1;
          end else if (!has2) begin
            state_next = ST_IDLE;
          end else if ((byte1 == 8'd0) || (byte1 > MAX_LEN)) begin
            // Drop only the header so the LEN byte is re-hunted
            fifo_r_en    = 1'b1;
            fifo_r_count = 6'd1;
            err_next     = 1'b1;
            code_next    = ERR_LEN;
          end else begin
            fifo_r_en      = 1'b1;
            fifo_r_count   = 6'd2;
            remaining_next = REM_W'(byte1);
            sum_next       = byte1;
            state_next     = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          m_valid = has1;
          if (expired) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
            code_next  = ERR_TIMEOUT;
          end else if (has1 && m_ready) begin
            fifo_r_en      = 1'b1;
            fifo_r_count   = 6'd1;
            sum_next       = chk_add(sum, byte0);
            remaining_next = remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state_next = ST_CHECK;
            end else begin
              state_next = ST_PAYLOAD;
            end
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
        ST_CHECK: begin
          if (expired) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
            code_next  = ERR_TIMEOUT;
          end else if (has1) begin
            fifo_r_en    = 1'b1;
            fifo_r_count = 6'd1;
            state_next   = ST_IDLE;
            if (byte0 == sum) begin
              ok_next = 1'b1;
            end else begin
              err_next  = 1'b1;
              code_next = ERR_CHK;
            end
          end else begin
            state_next = ST_CHECK;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // State, checksum, length and status pulse registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sum       <= 8'd0;
      remaining <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_next;
      sum       <= sum_next;
      remaining <= remaining_next;
      frame_ok  <= ok_next;
      frame_err <= err_next;
      err_code  <= code_next;
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
// Self-checking bench for frame_parser. The bench plays the FIFO (a byte
// queue popped on fifo_r_en), builds the expected payload/event sequence
// by parsing each loaded byte stream in software, and compares every cycle.
module tb_frame_parser;
  import frame_pkg::*;

  localparam int WIN  = 2;
  localparam int MAXP = 32;
  localparam int TO   = 16;
  localparam int LW   = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic            enable;
  logic [WIN*8-1:0] fifo_data;
  logic [LW-1:0]   fifo_level;
  logic            fifo_r_en;
  logic [5:0]      fifo_r_count;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready;
  logic            frame_ok;
  logic            frame_err;
  logic [1:0]      err_code;

  frame_parser #(
    .WIN(WIN), .HDR(8'hA5), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO), .LEVEL_W(LW)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo_data(fifo_data), .fifo_level(fifo_level),
    .fifo_r_en(fifo_r_en), .fifo_r_count(fifo_r_count),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // FIFO contents and expected results
  logic [7:0] q[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         exp_evt[$];   // 0 = frame_ok, 8+n = frame_err with err_code n

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_total = 0;
  int pulse_count = 0;
  int err_cyc = -1;
  logic last_pop = 1'b0;
  logic pop_en;
  logic [5:0] pop_n;
  logic [7:0] stream[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_window();
    fifo_level = LW'(q.size());
    fifo_data  = '0;
    if (q.size() > 0) fifo_data[7:0]  = q[0];
    if (q.size() > 1) fifo_data[15:8] = q[1];
  endtask

  // Reference parse of a byte stream: what the payload stream and status
  // events must be. starve = the stream ends inside a frame and stays empty.
  task automatic model_frames(input logic [7:0] s[$], input bit starve);
    int i = 0;
    int len;
    logic [7:0] acc;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
      end else if (i + 1 >= s.size()) begin
        break;
      end else begin
        len = int'(s[i+1]);
        if (len == 0 || len > MAXP) begin
          exp_evt.push_back(8 + 1);
          i++;
        end else begin
          acc = s[i+1];
          for (int k = 0; k < len; k++) begin
            if (i + 2 + k < s.size()) begin
              exp_data.push_back(s[i+2+k]);
              exp_last.push_back(k == len - 1);
              acc = acc + s[i+2+k];
            end
          end
          if (i + 2 + len < s.size()) begin
            exp_evt.push_back((s[i+2+len] == acc) ? 0 : 8 + 2);
            i += len + 3;
          end else begin
            if (starve) exp_evt.push_back(8 + 3);
            break;
          end
        end
      end
    end
  endtask

  task automatic load(input logic [7:0] s[$], input bit starve);
    model_frames(s, starve);
    foreach (s[k]) q.push_back(s[k]);
    drive_window();
  endtask

  // Per-cycle comparison against the model (called at the falling edge)
  task automatic compare();
    int code;
    logic [7:0] ed;
    logic el;
    if (m_valid && m_ready) begin
      if (exp_data.size() == 0) begin
        check("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        ed = exp_data.pop_front();
        el = exp_last.pop_front();
        check("m_data", {24'd0, m_data}, {24'd0, ed});
        check("m_last", {31'd0, m_last}, {31'd0, el});
      end
    end
    if (frame_ok || frame_err) begin
      pulse_count++;
      code = frame_ok ? 0 : 8 + int'(err_code);
      if (exp_evt.size() == 0) begin
        check("unexpected_event", code, 32'hFFFF_FFFF);
      end else begin
        check("event_code", code, exp_evt.pop_front());
        if (code == 8 + 3) err_cyc = cyc;
        else check("pulse_after_pop", {31'd0, last_pop}, 32'd1);
      end
    end
    check("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
    if (!frame_err) check("err_code_idle", {30'd0, err_code}, 32'd0);
  endtask

  // One clock: compare, sample pop request, then act as the FIFO
  task automatic tick();
    logic [7:0] tmp;
    @(negedge clk);
    compare();
    pop_en = fifo_r_en;
    pop_n  = fifo_r_count;
    @(posedge clk);
    #1;
    if (pop_en) begin
      check("pop_count_legal", 32'(pop_n == 6'd1 || pop_n == 6'd2), 32'd1);
      check("pop_within_level", 32'(q.size() >= int'(pop_n)), 32'd1);
      for (int k = 0; k < int'(pop_n); k++) begin
        if (q.size() > 0) tmp = q.pop_front();
      end
      pop_total += int'(pop_n);
    end
    last_pop = pop_en;
    drive_window();
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (n < budget && (exp_data.size() + exp_evt.size() + q.size()) != 0) begin
      tick();
      n++;
    end
    check("frame_drained", exp_data.size() + exp_evt.size() + q.size(), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_en"},   {31'd0, fifo_r_en}, 32'd0);
    check({tag, "_r_count"}, {26'd0, fifo_r_count}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
    check({tag, "_ok"},     {31'd0, frame_ok}, 32'd0);
    check({tag, "_err"},    {31'd0, frame_err}, 32'd0);
    check({tag, "_code"},   {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    int p0;
    int c0;
    int pc;
    int n;
    resetn  = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    drive_window();
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) tick();

    // Good frame
    stream = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    load(stream, 1'b0);
    check("model_good_beats", exp_data.size(), 32'd3);
    check("model_good_last_byte", {24'd0, exp_data[2]}, 32'h30);
    check("model_good_last_flag", {31'd0, exp_last[2]}, 32'd1);
    check("model_good_event", exp_evt[0], 32'd0);
    p0 = pop_total;
    run_until_done(30);
    check("good_pop_total", pop_total - p0, 32'd6);

    // Garbage then frame
    stream = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    load(stream, 1'b0);
    check("model_garbage_data", {24'd0, exp_data[0]}, 32'h7E);
    check("model_garbage_events", exp_evt.size(), 32'd1);
    p0 = pop_total;
    run_until_done(30);
    check("garbage_pop_total", pop_total - p0, 32'd6);

    // Bad length then a good frame
    stream = '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'h55, 8'h56};
    load(stream, 1'b0);
    check("model_badlen_first", exp_evt[0], 32'd9);
    check("model_badlen_second", exp_evt[1], 32'd0);
    tick();
    check("hdr_pop_alone", q.size(), 32'd5);
    run_until_done(30);

    // Bad checksum
    stream = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    load(stream, 1'b0);
    check("model_badchk_event", exp_evt[0], 32'd10);
    run_until_done(30);
    check("badchk_idle_no_valid", {31'd0, m_valid}, 32'd0);

    // Back-pressure, then starvation timeout
    m_ready = 1'b0;
    stream = '{8'hA5, 8'h02, 8'h11};
    load(stream, 1'b1);
    check("model_starve_event", exp_evt[0], 32'd11);
    tick();
    p0 = pop_total;
    repeat (40) tick();
    check("bp_no_pop", pop_total - p0, 32'd0);
    check("bp_no_timeout", err_cyc, 32'hFFFF_FFFF);
    check("bp_valid_held", {31'd0, m_valid}, 32'd1);
    check("bp_data_held", {24'd0, m_data}, 32'h11);
    m_ready = 1'b1;
    tick();
    c0 = cyc;
    check("starve_level_zero", q.size(), 32'd0);
    n = 0;
    while (err_cyc < 0 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", err_cyc - c0, 32'd16);
    check("timeout_event_seen", exp_evt.size(), 32'd0);
    repeat (2) tick();

    // Reset mid-payload
    stream = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    load(stream, 1'b0);
    repeat (2) tick();
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    exp_data.delete();
    exp_last.delete();
    exp_evt.delete();
    drive_window();
    pc = pulse_count;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("midreset_no_pulse", pulse_count - pc, 32'd0);
    load(stream, 1'b0);
    run_until_done(30);

    // Enable low freezes the parser with a full frame queued
    enable = 1'b0;
    load(stream, 1'b0);
    p0 = pop_total;
    repeat (10) begin
      tick();
      check("disabled_no_pop_req", {31'd0, fifo_r_en}, 32'd0);
      check("disabled_no_valid", {31'd0, m_valid}, 32'd0);
    end
    check("disabled_pop_total", pop_total - p0, 32'd0);
    enable = 1'b1;
    run_until_done(30);
    check("enabled_pop_total", pop_total - p0, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_parser.md
Name: frame_parser

Overview:
- Consumes the byte window of the multi-output receive FIFO and extracts framed packets.
- Frame format: header HDR, length LEN (1..MAX_PAYLOAD), LEN payload bytes, checksum CHK.
- CHK = (LEN + sum of payload bytes) mod 256.
- Streams payload bytes downstream with valid/ready. Flags each frame as good or bad at its end. Drives the FIFO pop interface (r_en/r_count).

Parameters:
- WIN, 2, bytes visible in fifo_data window; must be >= 2; low byte is oldest.
- HDR, 8'hA5, frame header byte.
- MAX_PAYLOAD, 32, largest legal LEN.
- TIMEOUT_CYCLES, 50000, starvation limit inside a frame.
- LEVEL_W, 8, width of fifo_level.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset: asynchronous, active-low.
- enable  input  1  global enable; low freezes all state.
- fifo_data  input  WIN*8  FIFO output window; [7:0] is the oldest byte.
- fifo_level  input  LEVEL_W  bytes currently held by the FIFO.
- fifo_r_en  output  1  pop request.
- fifo_r_count  output  6  bytes to pop (1 or 2).
- m_data  output  8  payload byte.
- m_valid  output  1  payload byte valid.
- m_last  output  1  final payload byte of the frame.
- m_ready  input  1  downstream accepts byte.
- frame_ok  output  1  one-cycle pulse: checksum matched.
- frame_err  output  1  one-cycle pulse: frame discarded or corrupt.
- err_code  output  2  held with frame_err: 1 bad length, 2 checksum, 3 timeout; 0 otherwise.

Behaviour:
- Reset values: state=IDLE, fifo_r_en=0, fifo_r_count=0, m_valid=0, m_last=0, frame_ok=0, frame_err=0, err_code=0, sum=0, remaining=0, timer=0.
- Pops are requested combinationally. fifo_data reflects the pop on the next cycle. At most one pop request per cycle.
- IDLE (hunt):
  - level>=1 and byte0!=HDR: pop 1, stay.
  - byte0==HDR and level>=2, with LEN=byte1:
    - LEN==0 or LEN>MAX_PAYLOAD: pop 1 (header only, allows resync on LEN byte). Pulse frame_err, err_code=1.
    - Otherwise: pop 2, remaining<=LEN, sum<=LEN, go PAYLOAD.
  - byte0==HDR and level<2: wait, no pop.
- PAYLOAD:
  - m_valid = (level>=1); m_data = byte0; m_last = (remaining==1).
  - On m_valid && m_ready: pop 1, sum<=sum+byte0, remaining<=remaining-1. If remaining==1, go CHECK.
  - m_ready low: no pop, outputs held combinationally from the window.
- CHECK:
  - When level>=1: pop 1.
  - byte0==sum: pulse frame_ok. Otherwise pulse frame_err, err_code=2.
  - Go IDLE. Pulses are registered, asserted the cycle after the CHK pop.
- Timeout:
  - timer counts only in PAYLOAD/CHECK while level==0; clears on any pop or state change.
  - Back-pressure (m_ready=0 with level>=1) does not count.
  - timer reaching TIMEOUT_CYCLES-1: pulse frame_err, err_code=3, go IDLE, no pop.
- enable=0: no pops, m_valid=0, state/sum/remaining/timer held, pulses forced 0.
- Reset mid-frame: return to IDLE immediately, no frame_err pulse; partially streamed payload is not flagged.
- Arithmetic: sum is 8-bit wrap-around. remaining is $clog2(MAX_PAYLOAD+1) bits. fifo_level is compared unsigned.
- frame_ok and frame_err are never high together. err_code returns to 0 the cycle after frame_err.

Decomposition:
- frame_pkg:
  - HDR default.
  - err_code constants ERR_NONE/ERR_LEN/ERR_CHK/ERR_TIMEOUT.
  - State encoding IDLE/PAYLOAD/CHECK.
- Sub-module frame_timeout: starvation counter with clear/run inputs and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Good frame: FIFO holds A5 03 10 20 30 63, m_ready=1 -> m_data 10,20,30 on consecutive accepts; m_last with 30; frame_ok one cycle after CHK pop; 6 bytes popped in total.
- Garbage then frame: 00 FF A5 01 7E 7F -> single pops of 00 and FF, then m_data 7E with m_last, frame_ok; no frame_err.
- Bad length: A5 00 A5 01 55 56 -> frame_err with err_code=1; header popped alone; then the next frame yields 55 and frame_ok.
- Bad checksum: A5 02 01 02 00 -> bytes 01,02 streamed; frame_err with err_code=2; state IDLE.
- Back-pressure and starvation: TIMEOUT_CYCLES=16; feed A5 02 11. Hold m_ready=0 for 40 cycles -> no timeout, no pop. Release, then starve -> frame_err with err_code=3 exactly 16 cycles after level hits 0.
- Reset and enable: assert resetn=0 mid-payload -> all outputs at reset values, no pulse. enable=0 with a full frame queued -> fifo_r_en stays 0.
